leitor_registradores: RTL and testbench
=======================================

# leitor_registradores

Register-file dump engine for the single-cycle MIPS core. On a start pulse it walks register addresses 0..31 through one read port of the register bank. Each register's contents are captured and streamed out, tagged with the register index, over a valid/ready interface, for the debug/trace path and for testbench state comparison. It is the reader for the bank's read port; it never drives the write side.

## Interface
- NUM_REGS, 32, number of registers scanned (indices 0..NUM_REGS-1)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  input  1  begin a dump; sampled only in IDLE
- abort  input  1  cancel a dump in progress; ignored in IDLE
- ReadRegister  output  ADDR_W  address driven to the bank read port (ReadRegister1 or ReadRegister2)
- ReadData  input  DATA_W  combinational data returned by the bank for ReadRegister
- out_valid  output  1  out_index/out_data hold a captured register
- out_ready  input  1  consumer accepts the current beat
- out_index  output  ADDR_W  index of the register in out_data
- out_data  output  DATA_W  captured register contents
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, READ, SEND, DONE. State, idx, out_* and done are all registers.
- ReadRegister is always the registered idx. It is never combinational from inputs.
- IDLE:
  - start=1 → idx←0, go to READ.
  - start=0 → stay.
- READ:
  - The bank is combinational, so ReadData is valid in this cycle.
  - At the edge: out_data←ReadData, out_index←idx, out_valid←1, go to SEND.
- SEND:
  - out_valid=1. out_index and out_data are held stable until the handshake.
  - Handshake (out_valid && out_ready) with idx<NUM_REGS-1 → idx←idx+1, out_valid←0, go to READ.
  - Handshake with idx==NUM_REGS-1 → out_valid←0, go to DONE.
- DONE: done=1 for exactly this cycle. idx←0, go to IDLE.
- abort in READ, SEND or DONE:
  - Next edge: go to IDLE, out_valid←0, idx←0, done←0.
  - abort beats a simultaneous handshake; that beat counts as not delivered.
- start while busy is ignored. start and abort together in IDLE → start wins; abort is meaningless there.
- Register 0 is streamed like any other. The bank returns 0 for it, so out_data=0 for index 0.
- idx increments in ADDR_W bits. The last index is compared explicitly, so no wrap past NUM_REGS-1 is ever issued.
- Bank contents written during a dump are not protected. Each beat reflects the bank at its READ cycle.

## Timing
- Reset (async assert, sync deassert at the consumer): state=IDLE, idx=0, ReadRegister=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0.
- Reset mid-dump: immediate return to the reset values. No done pulse.
- Latency: start sampled at edge E0.
  - READ during cycle E0→E1.
  - out_valid=1 after E1.
  - With out_ready held high, a beat is accepted every 2 cycles.
- Full dump with out_ready=1: 2·NUM_REGS cycles from the start edge to the last acceptance. done is high in the following cycle. busy is high for 2·NUM_REGS+1 cycles.
- Backpressure: out_ready=0 stalls SEND indefinitely, with no change to out_*.
- A new start is accepted the cycle after DONE (in IDLE).

## Structure
- Shared package (e.g. mips_pkg):
  - state encoding localparams: IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3.
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, shared with the bank.
- Single flat module, no sub-module required. The idx counter and the FSM are small enough inline.
- Instantiated next to the bank; its ReadRegister is muxed onto a read port in debug mode.

## Test plan
- Bank preloaded so that reg[i]=32'hA000_0000+i, out_ready=1, pulse start → 32 beats with index 0..31. Data is 0 for index 0 and 32'hA000_0000+i otherwise. done pulses once at cycle 65 after start; busy deasserts at the same edge.
- out_ready toggled 1-of-3 cycles → same 32 beats, in order, none duplicated. out_index/out_data stay stable while out_valid && !out_ready.
- abort asserted in SEND of index 7, with out_ready=1 in the same cycle → next cycle IDLE, out_valid=0, done never pulses. A following start restarts at index 0.
- reset asserted asynchronously mid-cycle during index 12 → outputs go to their reset values immediately without waiting for clk. After release, start yields a full dump from index 0.
- start re-pulsed while busy at index 3 → ignored, dump continues to 31 with a single done. start in the cycle after done → new dump accepted.
- Bank write to reg[20]=32'hDEAD_BEEF while the dump sits at index 10 → the beat for index 20 carries 32'hDEAD_BEEF.

Source files
------------

// File: rtl/leitor_registradores_pkg.sv
// Shared register-bank geometry and dump-engine state encoding.
package leitor_registradores_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/leitor_registradores.sv
// Register-file dump engine: walks the bank read port over all registers and
// streams {index, data} beats out over a valid/ready interface.
module leitor_registradores
  import leitor_registradores_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] ReadRegister,
  input  logic [REG_DATA_W-1:0] ReadData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic [REG_DATA_W-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned ADDR_W = REG_ADDR_W;
  localparam int unsigned DATA_W = REG_DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic              out_valid_d;
  logic [ADDR_W-1:0] out_index_d;
  logic [DATA_W-1:0] out_data_d;
  logic              busy_d;
  logic              done_d;

  assign ReadRegister = idx;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      out_valid <= out_valid_d;
      out_index <= out_index_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    out_valid_d = out_valid;
    out_index_d = out_index;
    out_data_d  = out_data;

    unique case (state)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        out_data_d  = ReadData;
        out_index_d = idx;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          if (idx == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides any handshake in the same cycle; the beat is dropped.
    if (abort && (state != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_leitor_registradores.sv
// Directed bench for leitor_registradores with a bank model and beat scoreboard.
module tb_leitor_registradores;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  ReadRegister;
  logic [31:0] ReadData;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] bank [32];
  logic [36:0] exp_q [$];
  logic [36:0] held;
  logic        prev_stall;
  int          passed = 0;
  int          total  = 0;
  int          beats  = 0;
  int          dones  = 0;
  int          d0;

  leitor_registradores dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .ReadRegister (ReadRegister),
    .ReadData     (ReadData),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
  );

  // MIPS bank read port: register 0 is hardwired to zero.
  assign ReadData = (ReadRegister == 5'd0) ? 32'd0 : bank[ReadRegister];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input int ovr, input logic [31:0] v);
    logic [31:0] d;
    for (int i = 0; i < 32; i++) begin
      d = (i == 0) ? 32'd0 : bank[i];
      if (i == ovr) d = v;
      exp_q.push_back({5'(i), d});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idx(input int k, input string tag);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (out_valid && out_index == 5'(k)) found = 1'b1;
      else step(1);
    end
    if (!found) chk(tag, 64'(found), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (done) found = 1'b1;
      else step(1);
    end
    if (!found) chk(tag, 64'(found), 64'd1);
  endtask

  // Output monitor: scoreboard on accepted beats, hold check while stalled.
  always @(negedge clk) begin
    if (out_valid && out_ready && !abort && !reset) begin
      beats++;
      if (exp_q.size() == 0) chk("extra_beat", 64'({out_index, out_data}), 64'd0);
      else chk("beat", 64'({out_index, out_data}), 64'(exp_q.pop_front()));
    end
    if (prev_stall && out_valid && !reset)
      chk("hold", 64'({out_index, out_data}), 64'(held));
    prev_stall = out_valid && !out_ready && !abort && !reset;
    held       = {out_index, out_data};
    if (done) dones++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    prev_stall = 1'b0; held = '0;
    for (int i = 0; i < 32; i++) bank[i] = 32'hA000_0000 + 32'(i);

    #2;
    chk("reset_outs", 64'({ReadRegister, out_valid, out_index, out_data, busy, done}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(2);

    // Full dump with out_ready held high; check exact timing.
    out_ready = 1'b1; beats = 0; d0 = dones;
    push_dump(-1, 32'd0);
    pulse_start();
    chk("t1_read_state", 64'({busy, out_valid, ReadRegister}), 64'({1'b1, 1'b0, 5'd0}));
    step(1);
    chk("t1_first_beat", 64'({out_valid, out_index, out_data}), 64'({1'b1, 5'd0, 32'd0}));
    step(63);
    chk("t1_done_cycle", 64'({done, busy}), 64'({1'b1, 1'b1}));
    step(1);
    chk("t1_after_done", 64'({done, busy, out_valid}), 64'd0);
    chk("t1_beats", 64'(beats), 64'd32);
    chk("t1_dones", 64'(dones - d0), 64'd1);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: out_ready high one cycle in three.
    beats = 0; d0 = dones;
    push_dump(-1, 32'd0);
    pulse_start();
    for (int c = 0; c < 600 && !done; c++) begin
      out_ready = (c % 3 == 0);
      step(1);
    end
    chk("t2_done_seen", 64'(done), 64'd1);
    out_ready = 1'b1;
    step(1);
    chk("t2_beats", 64'(beats), 64'd32);
    chk("t2_dones", 64'(dones - d0), 64'd1);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Abort in SEND of index 7 coinciding with a handshake.
    beats = 0; d0 = dones;
    push_dump(-1, 32'd0);
    pulse_start();
    wait_idx(7, "t3_wait_idx7");
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t3_abort_outs", 64'({out_valid, busy, ReadRegister, done}), 64'd0);
    chk("t3_beats", 64'(beats), 64'd7);
    exp_q.delete();
    step(5);
    chk("t3_no_done", 64'(dones - d0), 64'd0);
    beats = 0;
    push_dump(-1, 32'd0);
    pulse_start();
    chk("t3_restart", 64'({busy, ReadRegister}), 64'({1'b1, 5'd0}));
    wait_done("t3_wait_done");
    step(2);
    chk("t3_restart_beats", 64'(beats), 64'd32);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-cycle during index 12.
    beats = 0; d0 = dones;
    push_dump(-1, 32'd0);
    pulse_start();
    wait_idx(12, "t4_wait_idx12");
    #2;
    reset = 1'b1;
    #1;
    chk("t4_async_reset", 64'({ReadRegister, out_valid, out_index, out_data, busy, done}), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t4_no_done", 64'(dones - d0), 64'd0);
    step(1);
    beats = 0;
    push_dump(-1, 32'd0);
    pulse_start();
    wait_done("t4_wait_done");
    step(2);
    chk("t4_beats", 64'(beats), 64'd32);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // start while busy is ignored; start right after DONE is accepted.
    beats = 0; d0 = dones;
    push_dump(-1, 32'd0);
    pulse_start();
    wait_idx(3, "t5_wait_idx3");
    pulse_start();
    wait_done("t5_wait_done1");
    chk("t5_first_beats", 64'(beats), 64'd32);
    step(1);
    push_dump(-1, 32'd0);
    pulse_start();
    chk("t5_restart", 64'({busy, ReadRegister}), 64'({1'b1, 5'd0}));
    wait_done("t5_wait_done2");
    step(2);
    chk("t5_beats", 64'(beats), 64'd64);
    chk("t5_dones", 64'(dones - d0), 64'd2);
    chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // Bank write during the dump is visible in a later beat.
    beats = 0;
    push_dump(20, 32'hDEAD_BEEF);
    pulse_start();
    wait_idx(10, "t6_wait_idx10");
    bank[20] = 32'hDEAD_BEEF;
    wait_done("t6_wait_done");
    step(2);
    chk("t6_beats", 64'(beats), 64'd32);
    chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
